// File: rtl/tug_match_ctrl_if.sv
// Player/tick inputs and display-facing outputs of the tug-of-war match sequencer.
interface tug_match_ctrl_if;
    logic       start;
    logic       tick;
    logic       l_pulse;
    logic       r_pulse;
    logic [3:0] pos;
    logic       play;
    logic [1:0] cd_val;
    logic [1:0] score_l;
    logic [1:0] score_r;
    logic [1:0] winner;
    logic       match_over;

    modport master (
        output start, tick, l_pulse, r_pulse,
        input  pos, play, cd_val, score_l, score_r, winner, match_over
    );

    modport slave (
        input  start, tick, l_pulse, r_pulse,
        output pos, play, cd_val, score_l, score_r, winner, match_over
    );
endinterface

// File: rtl/tug_match_ctrl.sv
// Tug-of-war match sequencer: countdown, rope position, round wins, scores and match winner.
module tug_match_ctrl #(
    parameter int CD_TICKS   = 3,
    parameter int HOLD_TICKS = 2,
    parameter int WIN_ROUNDS = 2
) (
    input  logic             clk,
    input  logic             rst,
    tug_match_ctrl_if.slave  bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_COUNTDOWN = 3'd1;
    localparam logic [2:0] S_PLAY      = 3'd2;
    localparam logic [2:0] S_ROUND_END = 3'd3;
    localparam logic [2:0] S_MATCH_END = 3'd4;

    localparam logic [3:0] POS_CENTRE = 4'd8;
    localparam logic [1:0] CD_LOAD    = 2'(CD_TICKS);
    localparam logic [3:0] HOLD_LOAD  = 4'(HOLD_TICKS);
    localparam logic [1:0] WIN_COUNT  = 2'(WIN_ROUNDS);

    logic [2:0] state;
    logic [3:0] hold_cnt;
    logic [1:0] round_winner_score;

    assign round_winner_score = (bus.winner == 2'b01) ? bus.score_l : bus.score_r;

    // Every output is a register; in the side states presses are simply never looked at.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            hold_cnt       <= 4'd0;
            bus.pos        <= POS_CENTRE;
            bus.play       <= 1'b0;
            bus.cd_val     <= 2'd0;
            bus.score_l    <= 2'd0;
            bus.score_r    <= 2'd0;
            bus.winner     <= 2'b00;
            bus.match_over <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.pos <= POS_CENTRE;
                    if (bus.start) begin
                        bus.score_l <= 2'd0;
                        bus.score_r <= 2'd0;
                        bus.winner  <= 2'b00;
                        bus.cd_val  <= CD_LOAD;
                        state       <= S_COUNTDOWN;
                    end
                end

                S_COUNTDOWN: begin
                    if (bus.tick) begin
                        if (bus.cd_val == 2'd1) begin
                            bus.cd_val <= 2'd0;
                            bus.play   <= 1'b1;
                            state      <= S_PLAY;
                        end else begin
                            bus.cd_val <= bus.cd_val - 2'd1;
                        end
                    end
                end

                S_PLAY: begin
                    if (bus.l_pulse && !bus.r_pulse) begin
                        if (bus.pos == 4'd14) begin
                            bus.pos     <= 4'd15;
                            bus.score_l <= bus.score_l + 2'd1;
                            bus.winner  <= 2'b01;
                            bus.play    <= 1'b0;
                            hold_cnt    <= HOLD_LOAD;
                            state       <= S_ROUND_END;
                        end else if (bus.pos < 4'd14) begin
                            bus.pos <= bus.pos + 4'd1;
                        end
                    end else if (bus.r_pulse && !bus.l_pulse) begin
                        if (bus.pos == 4'd2) begin
                            bus.pos     <= 4'd1;
                            bus.score_r <= bus.score_r + 2'd1;
                            bus.winner  <= 2'b10;
                            bus.play    <= 1'b0;
                            hold_cnt    <= HOLD_LOAD;
                            state       <= S_ROUND_END;
                        end else if (bus.pos > 4'd2) begin
                            bus.pos <= bus.pos - 4'd1;
                        end
                    end
                end

                // The tick that empties the hold decides between another round and match end.
                S_ROUND_END: begin
                    if (bus.tick) begin
                        if (hold_cnt <= 4'd1) begin
                            hold_cnt <= 4'd0;
                            if (round_winner_score == WIN_COUNT) begin
                                bus.match_over <= 1'b1;
                                state          <= S_MATCH_END;
                            end else begin
                                bus.pos    <= POS_CENTRE;
                                bus.winner <= 2'b00;
                                bus.cd_val <= CD_LOAD;
                                state      <= S_COUNTDOWN;
                            end
                        end else begin
                            hold_cnt <= hold_cnt - 4'd1;
                        end
                    end
                end

                S_MATCH_END: begin
                    if (bus.start) begin
                        bus.score_l    <= 2'd0;
                        bus.score_r    <= 2'd0;
                        bus.winner     <= 2'b00;
                        bus.match_over <= 1'b0;
                        bus.pos        <= POS_CENTRE;
                        bus.cd_val     <= CD_LOAD;
                        state          <= S_COUNTDOWN;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
